// File: rtl/rv32i_multicycle_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle control unit: FSM states, PC source,
// write-back source and the recognised base opcodes.
package rv32i_multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE_S0      = 3'd0,
    FETCH_S1     = 3'd1,
    DECODE_S2    = 3'd2,
    EXECUTE_S3   = 3'd3,
    MEM_S4       = 3'd4,
    WRITEBACK_S5 = 3'd5
  } RV32I_CONTROL_UNIT_FSM_t;

  typedef enum logic [1:0] {
    PC_PLUS_4   = 2'd0,
    PC_PLUS_IMM = 2'd1,
    ALU_OUT     = 2'd2
  } PC_INPUT_SELECTOR_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } WB_SELECTOR_t;

  typedef enum logic [6:0] {
    LOAD       = 7'b0000011,
    FENCE      = 7'b0001111,
    I_TYPE     = 7'b0010011,
    AUIPC      = 7'b0010111,
    STORE      = 7'b0100011,
    R_TYPE     = 7'b0110011,
    LUI        = 7'b0110111,
    B_TYPE     = 7'b1100011,
    JALR       = 7'b1100111,
    JAL        = 7'b1101111,
    I_ENV_TYPE = 7'b1110011
  } RV32I_OPCODE_t;

  function automatic logic is_rv32i_opcode(input logic [6:0] op);
    case (op)
      LOAD, FENCE, I_TYPE, AUIPC, STORE, R_TYPE,
      LUI, B_TYPE, JALR, JAL, I_ENV_TYPE: is_rv32i_opcode = 1'b1;
      default:                            is_rv32i_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_multicycle_ctrl_mem_timeout.sv
// Wait-cycle counter for the shared memory port; expired flags the last
// permitted waiting cycle so a response arriving in it still wins.
module rv32i_mem_timeout #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_W-1:0] count_r;

  // Count waiting cycles; clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + TMO_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r >= TMO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/mem/write-back
// and drives the datapath strobes and the shared memory port.
module rv32i_multicycle_ctrl
  import rv32i_multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [6:0] opcode_i,
  input  logic       branch_taken_i,
  input  logic       mem_rvalid_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       mem_sel_data_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       rf_we_o,
  output logic [1:0] wb_sel_o,
  output logic       halt_o,
  output logic       illegal_o,
  output logic       bus_err_o,
  output logic [2:0] state_o
);

  RV32I_CONTROL_UNIT_FSM_t state_r, state_nxt_s;
  PC_INPUT_SELECTOR_t      pc_sel_s;
  WB_SELECTOR_t            wb_sel_s;

  logic mem_req_s, mem_we_s, mem_sel_data_s, ir_we_s, pc_we_s, rf_we_s;
  logic set_halt_s, set_illegal_s, set_bus_err_s;
  logic tmo_clear_s, tmo_en_s, tmo_expired_s;
  logic halt_r, illegal_r, bus_err_r;

  rv32i_mem_timeout #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMO_W       (TMO_W)
  ) u_mem_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear_s),
    .enable  (tmo_en_s),
    .expired (tmo_expired_s)
  );

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt_s    = state_r;
    mem_req_s      = 1'b0;
    mem_we_s       = 1'b0;
    mem_sel_data_s = 1'b0;
    ir_we_s        = 1'b0;
    pc_we_s        = 1'b0;
    rf_we_s        = 1'b0;
    pc_sel_s       = PC_PLUS_4;
    wb_sel_s       = WB_ALU;
    set_halt_s     = 1'b0;
    set_illegal_s  = 1'b0;
    set_bus_err_s  = 1'b0;
    tmo_clear_s    = 1'b1;
    tmo_en_s       = 1'b0;
    case (state_r)
      IDLE_S0: begin
        if (start_i) begin
          state_nxt_s = FETCH_S1;
        end else begin
          state_nxt_s = IDLE_S0;
        end
      end
      FETCH_S1: begin
        mem_req_s = 1'b1;
        if (mem_rvalid_i) begin
          ir_we_s     = 1'b1;
          state_nxt_s = DECODE_S2;
        end else if (tmo_expired_s) begin
          set_bus_err_s = 1'b1;
          state_nxt_s   = IDLE_S0;
        end else begin
          tmo_clear_s = 1'b0;
          tmo_en_s    = 1'b1;
        end
      end
      DECODE_S2: begin
        if (is_rv32i_opcode(opcode_i)) begin
          state_nxt_s = EXECUTE_S3;
        end else begin
          set_illegal_s = 1'b1;
          state_nxt_s   = IDLE_S0;
        end
      end
      EXECUTE_S3: begin
        case (opcode_i)
          LOAD, STORE: state_nxt_s = MEM_S4;
          B_TYPE: begin
            pc_we_s     = 1'b1;
            pc_sel_s    = branch_taken_i ? PC_PLUS_IMM : PC_PLUS_4;
            state_nxt_s = FETCH_S1;
          end
          I_ENV_TYPE: begin
            set_halt_s  = 1'b1;
            state_nxt_s = IDLE_S0;
          end
          default: state_nxt_s = WRITEBACK_S5;
        endcase
      end
      MEM_S4: begin
        mem_req_s      = 1'b1;
        mem_sel_data_s = 1'b1;
        mem_we_s       = (opcode_i == STORE);
        if (mem_rvalid_i) begin
          if (opcode_i == STORE) begin
            pc_we_s     = 1'b1;
            state_nxt_s = FETCH_S1;
          end else begin
            state_nxt_s = WRITEBACK_S5;
          end
        end else if (tmo_expired_s) begin
          set_bus_err_s = 1'b1;
          state_nxt_s   = IDLE_S0;
        end else begin
          tmo_clear_s = 1'b0;
          tmo_en_s    = 1'b1;
        end
      end
      WRITEBACK_S5: begin
        rf_we_s     = 1'b1;
        pc_we_s     = 1'b1;
        state_nxt_s = FETCH_S1;
        case (opcode_i)
          JAL: begin
            pc_sel_s = PC_PLUS_IMM;
            wb_sel_s = WB_PC4;
          end
          JALR: begin
            pc_sel_s = ALU_OUT;
            wb_sel_s = WB_PC4;
          end
          LUI:     wb_sel_s = WB_IMM;
          LOAD:    wb_sel_s = WB_MEM;
          default: wb_sel_s = WB_ALU;
        endcase
      end
      default: state_nxt_s = IDLE_S0;
    endcase
  end

  // State register and sticky status flags; flags clear when a new run starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE_S0;
      halt_r    <= 1'b0;
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE_S0) && start_i) begin
        halt_r    <= 1'b0;
        illegal_r <= 1'b0;
        bus_err_r <= 1'b0;
      end else begin
        halt_r    <= halt_r | set_halt_s;
        illegal_r <= illegal_r | set_illegal_s;
        bus_err_r <= bus_err_r | set_bus_err_s;
      end
    end
  end

  assign mem_req_o      = mem_req_s;
  assign mem_we_o       = mem_we_s;
  assign mem_sel_data_o = mem_sel_data_s;
  assign ir_we_o        = ir_we_s;
  assign pc_we_o        = pc_we_s;
  assign pc_sel_o       = pc_sel_s;
  assign rf_we_o        = rf_we_s;
  assign wb_sel_o       = wb_sel_s;
  assign halt_o         = halt_r;
  assign illegal_o      = illegal_r;
  assign bus_err_o      = bus_err_r;
  assign state_o        = state_r;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Randomized bench: a transaction-level model expands each instruction into the
// cycle-by-cycle control trace expected from the FSM rules and compares it.
module tb_rv32i_multicycle_ctrl;
  import rv32i_multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, start_i, branch_taken_i, mem_rvalid_i;
  logic [6:0] opcode_i;
  logic       mem_req_o, mem_we_o, mem_sel_data_o, ir_we_o, pc_we_o, rf_we_o;
  logic [1:0] pc_sel_o, wb_sel_o;
  logic       halt_o, illegal_o, bus_err_o;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  rv32i_multicycle_ctrl #(.MEM_TIMEOUT(16), .TMO_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .opcode_i       (opcode_i),
    .branch_taken_i (branch_taken_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_sel_data_o (mem_sel_data_o),
    .ir_we_o        (ir_we_o),
    .pc_we_o        (pc_we_o),
    .pc_sel_o       (pc_sel_o),
    .rf_we_o        (rf_we_o),
    .wb_sel_o       (wb_sel_o),
    .halt_o         (halt_o),
    .illegal_o      (illegal_o),
    .bus_err_o      (bus_err_o),
    .state_o        (state_o)
  );

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_FENCE = 7'b0001111, OP_IMM = 7'b0010011,
                         OP_AUIPC = 7'b0010111, OP_STORE = 7'b0100011, OP_REG = 7'b0110011,
                         OP_LUI = 7'b0110111, OP_BR = 7'b1100011, OP_JALR = 7'b1100111,
                         OP_JAL = 7'b1101111, OP_ENV = 7'b1110011;

  typedef struct packed {
    logic       start;
    logic       rv;
    logic       tk;
    logic [6:0] op;
    logic [9:0] outs;
    logic [2:0] st;
    logic [2:0] flags;
  } cyc_t;

  cyc_t       plan[$];
  bit         m_idle;
  logic [2:0] m_flags;   // {halt, illegal, bus_err}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] pk(input logic req, input logic we, input logic sel,
                                    input logic ir, input logic pcwe, input logic [1:0] pcs,
                                    input logic rf, input logic [1:0] wb);
    return {req, we, sel, ir, pcwe, pcs, rf, wb};
  endfunction

  function automatic logic legal(input logic [6:0] op);
    return op inside {OP_LOAD, OP_FENCE, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
                      OP_LUI, OP_BR, OP_JALR, OP_JAL, OP_ENV};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom_range(0, 127));
  endfunction

  task automatic push(input logic start, input logic rv, input logic tk, input logic [6:0] op,
                      input logic [9:0] outs, input logic [2:0] st);
    cyc_t e;
    e.start = start; e.rv = rv; e.tk = tk; e.op = op;
    e.outs = outs; e.st = st; e.flags = m_flags;
    plan.push_back(e);
  endtask

  // Expand one instruction into its expected per-cycle control trace.
  task automatic plan_instr(input logic [6:0] op, input logic tk, input int wf, input int wm);
    logic       st_op;
    logic [1:0] pcs, wb;
    if (m_idle) begin
      if (rb()) push(1'b0, rb(), rb(), rop(), 10'd0, IDLE_S0);
      push(1'b1, rb(), rb(), rop(), 10'd0, IDLE_S0);
      m_flags = 3'b000;
      m_idle  = 1'b0;
    end
    for (int i = 0; i < wf && i < 16; i++)
      push(1'b0, 1'b0, rb(), rop(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0), FETCH_S1);
    if (wf >= 16) begin
      m_flags[0] = 1'b1; m_idle = 1'b1; return;
    end
    push(1'b0, 1'b1, rb(), rop(), pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0), FETCH_S1);
    push(1'b0, rb(), rb(), op, 10'd0, DECODE_S2);
    if (!legal(op)) begin
      m_flags[1] = 1'b1; m_idle = 1'b1; return;
    end
    if (op == OP_BR) begin
      push(1'b0, rb(), tk, op, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tk ? 2'd1 : 2'd0, 1'b0, 2'd0),
           EXECUTE_S3);
      return;
    end
    push(1'b0, rb(), rb(), op, 10'd0, EXECUTE_S3);
    if (op == OP_ENV) begin
      m_flags[2] = 1'b1; m_idle = 1'b1; return;
    end
    if (op == OP_LOAD || op == OP_STORE) begin
      st_op = (op == OP_STORE);
      for (int i = 0; i < wm && i < 16; i++)
        push(1'b0, 1'b0, rb(), op, pk(1'b1, st_op, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0), MEM_S4);
      if (wm >= 16) begin
        m_flags[0] = 1'b1; m_idle = 1'b1; return;
      end
      push(1'b0, 1'b1, rb(), op, pk(1'b1, st_op, 1'b1, 1'b0, st_op, 2'd0, 1'b0, 2'd0), MEM_S4);
      if (st_op) return;
    end
    pcs = 2'd0; wb = 2'd0;
    if (op == OP_JAL)       begin pcs = 2'd1; wb = 2'd2; end
    else if (op == OP_JALR) begin pcs = 2'd2; wb = 2'd2; end
    else if (op == OP_LUI)  wb = 2'd3;
    else if (op == OP_LOAD) wb = 2'd1;
    push(1'b0, rb(), rb(), op, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pcs, 1'b1, wb), WRITEBACK_S5);
  endtask

  task automatic run_plan();
    cyc_t e;
    while (plan.size() > 0) begin
      e = plan.pop_front();
      @(negedge clk);
      start_i = e.start; mem_rvalid_i = e.rv; branch_taken_i = e.tk; opcode_i = e.op;
      #2;
      cyc++;
      check($sformatf("outs@%0d", cyc),
            32'({mem_req_o, mem_we_o, mem_sel_data_o, ir_we_o, pc_we_o, pc_sel_o, rf_we_o, wb_sel_o}),
            32'(e.outs));
      check($sformatf("state@%0d", cyc), 32'(state_o), 32'(e.st));
      check($sformatf("flags@%0d", cyc), 32'({halt_o, illegal_o, bus_err_o}), 32'(e.flags));
    end
  endtask

  task automatic do_instr(input logic [6:0] op, input logic tk, input int wf, input int wm);
    plan_instr(op, tk, wf, wm);
    run_plan();
  endtask

  function automatic int rwait();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 16;
    if (r == 1) return 15;
    return $urandom_range(0, 3);
  endfunction

  logic [6:0] ops[11] = '{OP_LOAD, OP_FENCE, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
                          OP_LUI, OP_BR, OP_JALR, OP_JAL, OP_ENV};

  initial begin
    logic [6:0] op;
    rst_n = 1'b0; start_i = 1'b1; opcode_i = 7'd0; branch_taken_i = 1'b0; mem_rvalid_i = 1'b1;
    repeat (2) begin
      @(negedge clk); #2;
      check("rst_outs", 32'({mem_req_o, mem_we_o, mem_sel_data_o, ir_we_o, pc_we_o, pc_sel_o,
                             rf_we_o, wb_sel_o, halt_o, illegal_o, bus_err_o}), 32'd0);
      check("rst_state", 32'(state_o), 32'(IDLE_S0));
    end
    @(negedge clk);
    rst_n = 1'b1; start_i = 1'b1; mem_rvalid_i = 1'b0;
    #2;
    check("rel_outs", 32'({mem_req_o, ir_we_o, pc_we_o, rf_we_o}), 32'd0);
    m_idle = 1'b0; m_flags = 3'b000;

    do_instr(OP_IMM, 1'b0, 0, 0);
    do_instr(OP_BR, 1'b1, 0, 0);
    do_instr(OP_BR, 1'b0, 0, 0);
    do_instr(OP_LOAD, 1'b0, 0, 3);
    do_instr(OP_STORE, 1'b0, 1, 0);
    do_instr(OP_IMM, 1'b0, 16, 0);
    do_instr(OP_JAL, 1'b0, 0, 0);
    do_instr(7'b1111111, 1'b0, 0, 0);
    do_instr(OP_ENV, 1'b0, 2, 0);
    do_instr(OP_JALR, 1'b0, 15, 0);
    do_instr(OP_LUI, 1'b0, 0, 0);
    do_instr(OP_LOAD, 1'b0, 0, 15);
    do_instr(OP_STORE, 1'b0, 0, 16);
    do_instr(OP_AUIPC, 1'b0, 1, 0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) op = rop();
      else op = ops[$urandom_range(0, 10)];
      do_instr(op, rb(), rwait(), rwait());
    end

    // Asynchronous reset while a fetch is outstanding.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; start_i = 1'b1; mem_rvalid_i = 1'b0;
    @(negedge clk); start_i = 1'b0; #2;
    check("async_pre_req", 32'(mem_req_o), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    check("async_req", 32'(mem_req_o), 32'd0);
    check("async_state", 32'(state_o), 32'(IDLE_S0));
    @(negedge clk); rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
